// File: rtl/contador_pkg.sv
// Shared constants and helpers for the BCD counter and its 7-segment decoders.
// Segment patterns are {g,f,e,d,c,b,a} with a lit segment as 1.
package contador_pkg;

  localparam logic [3:0] BCD_MAX = 4'd9;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  function automatic logic bcd_valid(input logic [3:0] nibble);
    return (nibble <= BCD_MAX);
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// One-digit BCD to 7-segment decoder with blanking and selectable polarity.
// Non-BCD codes and blanked digits show no lit segments.
module seg7_decoder
  import contador_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg
);

  logic [6:0] seg_on;

  always_comb begin
    seg_on = SEG_BLANK;
    if (!blank) begin
      case (bcd)
        4'd0:    seg_on = SEG_0;
        4'd1:    seg_on = SEG_1;
        4'd2:    seg_on = SEG_2;
        4'd3:    seg_on = SEG_3;
        4'd4:    seg_on = SEG_4;
        4'd5:    seg_on = SEG_5;
        4'd6:    seg_on = SEG_6;
        4'd7:    seg_on = SEG_7;
        4'd8:    seg_on = SEG_8;
        4'd9:    seg_on = SEG_9;
        default: seg_on = SEG_BLANK;
      endcase
    end
  end

  assign seg = ACTIVE_LOW ? ~seg_on : seg_on;

endmodule

// File: rtl/bcd_updown_counter_nd.sv
// N-digit BCD up/down counter with terminal value, parallel load, wrap/saturate
// and per-digit 7-segment outputs; counts on step edges or every enabled clock.
module bcd_updown_counter_nd
  import contador_pkg::*;
#(
  parameter int              NDIG           = 2,
  parameter logic [4*NDIG-1:0] TOP_BCD      = 8'h99,
  parameter int              USE_STEP       = 1,
  parameter int              SEG_ACTIVE_LOW = 1,
  parameter int              BLANK_LZ       = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                step,
  input  logic                up_dn,
  input  logic                wrap_en,
  input  logic                load,
  input  logic [4*NDIG-1:0]   load_val,
  output logic [4*NDIG-1:0]   count_bcd,
  output logic [7*NDIG-1:0]   hex,
  output logic                tc,
  output logic                ovf,
  output logic                err
);

  localparam int W = 4 * NDIG;

  logic          s1, s2, s3;
  logic          step_in;
  logic          cnt_req;
  logic          nibbles_ok;
  logic          load_ok;
  logic [W-1:0]  count_inc, count_dec;
  logic [W-1:0]  count_nxt;
  logic          tc_nxt, ovf_nxt, err_nxt;
  logic [NDIG-1:0] blank;

  // In free-run mode the chain sees a constant 0 so it never leaves its reset value.
  assign step_in = (USE_STEP != 0) ? step : 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= step_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign cnt_req = (USE_STEP != 0) ? (s2 & ~s3 & en) : en;

  always_comb begin
    nibbles_ok = 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      if (!bcd_valid(load_val[4*i +: 4])) nibbles_ok = 1'b0;
    end
  end

  // Valid BCD orders the same as binary, so a plain compare checks the limit.
  assign load_ok = nibbles_ok && (load_val <= TOP_BCD);

  always_comb begin
    logic carry;
    logic borrow;
    carry     = 1'b1;
    borrow    = 1'b1;
    count_inc = count_bcd;
    count_dec = count_bcd;
    for (int i = 0; i < NDIG; i++) begin
      if (carry) begin
        if (count_bcd[4*i +: 4] == BCD_MAX) begin
          count_inc[4*i +: 4] = 4'd0;
        end else begin
          count_inc[4*i +: 4] = count_bcd[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
      if (borrow) begin
        if (count_bcd[4*i +: 4] == 4'd0) begin
          count_dec[4*i +: 4] = BCD_MAX;
        end else begin
          count_dec[4*i +: 4] = count_bcd[4*i +: 4] - 4'd1;
          borrow = 1'b0;
        end
      end
    end
  end

  always_comb begin
    count_nxt = count_bcd;
    tc_nxt    = 1'b0;
    ovf_nxt   = ovf;
    err_nxt   = err;
    if (load) begin
      if (load_ok) begin
        count_nxt = load_val;
        ovf_nxt   = 1'b0;
      end else begin
        err_nxt = 1'b1;
      end
    end else if (cnt_req) begin
      if (up_dn) begin
        if (count_bcd == TOP_BCD) begin
          if (wrap_en) begin
            count_nxt = '0;
            tc_nxt    = 1'b1;
          end else begin
            ovf_nxt = 1'b1;
          end
        end else begin
          count_nxt = count_inc;
        end
      end else begin
        if (count_bcd == '0) begin
          if (wrap_en) begin
            count_nxt = TOP_BCD;
            tc_nxt    = 1'b1;
          end else begin
            ovf_nxt = 1'b1;
          end
        end else begin
          count_nxt = count_dec;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_bcd <= '0;
      tc        <= 1'b0;
      ovf       <= 1'b0;
      err       <= 1'b0;
    end else begin
      count_bcd <= count_nxt;
      tc        <= tc_nxt;
      ovf       <= ovf_nxt;
      err       <= err_nxt;
    end
  end

  // A digit is a leading zero when it and every digit above it are zero.
  always_comb begin
    logic upper_zero;
    upper_zero = 1'b1;
    blank      = '0;
    for (int i = NDIG - 1; i >= 0; i--) begin
      upper_zero = upper_zero & (count_bcd[4*i +: 4] == 4'd0);
      blank[i]   = (BLANK_LZ != 0) && (i != 0) && upper_zero;
    end
  end

  for (genvar g = 0; g < NDIG; g++) begin : g_digit
    seg7_decoder #(
      .ACTIVE_LOW (SEG_ACTIVE_LOW != 0)
    ) u_seg (
      .bcd   (count_bcd[4*g +: 4]),
      .blank (blank[g]),
      .seg   (hex[7*g +: 7])
    );
  end

endmodule

// File: tb/tb_bcd_updown_counter_nd.sv
// Self-checking bench: a 2-digit step-driven counter and a 3-digit free-running,
// leading-zero-blanked counter, both compared against an integer reference model.
module tb_bcd_updown_counter_nd;

  localparam int TOP_A = 59;
  localparam int TOP_B = 999;

  typedef struct {
    int cnt;
    bit tc;
    bit ovf;
    bit err;
  } mstate_t;

  logic        clk;
  logic        rst;
  logic        en_a, step_a, up_a, wrap_a, load_a;
  logic [7:0]  lv_a;
  logic [7:0]  count_a;
  logic [13:0] hex_a;
  logic        tc_a, ovf_a, err_a;
  logic        en_b, step_b, up_b, wrap_b, load_b;
  logic [11:0] lv_b;
  logic [11:0] count_b;
  logic [20:0] hex_b;
  logic        tc_b, ovf_b, err_b;

  int      checks;
  int      errors;
  int      edge_n;
  int      due_a[$];
  bit      last_a;
  mstate_t ma, mb;

  bcd_updown_counter_nd #(
    .NDIG(2), .TOP_BCD(8'h59), .USE_STEP(1), .SEG_ACTIVE_LOW(1), .BLANK_LZ(0)
  ) dut_a (
    .clk(clk), .rst(rst), .en(en_a), .step(step_a), .up_dn(up_a), .wrap_en(wrap_a),
    .load(load_a), .load_val(lv_a), .count_bcd(count_a), .hex(hex_a),
    .tc(tc_a), .ovf(ovf_a), .err(err_a)
  );

  bcd_updown_counter_nd #(
    .NDIG(3), .TOP_BCD(12'h999), .USE_STEP(0), .SEG_ACTIVE_LOW(1), .BLANK_LZ(1)
  ) dut_b (
    .clk(clk), .rst(rst), .en(en_b), .step(step_b), .up_dn(up_b), .wrap_en(wrap_b),
    .load(load_b), .load_val(lv_b), .count_bcd(count_b), .hex(hex_b),
    .tc(tc_b), .ovf(ovf_b), .err(err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] seg_pat(input int d);
    case (d)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
      8: return 7'h7F;  9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  function automatic bit nibbles_ok(input logic [31:0] v, input int ndig);
    for (int i = 0; i < ndig; i++) if (v[4*i +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int bcd_to_int(input logic [31:0] v, input int ndig);
    int r = 0;
    for (int i = ndig - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [31:0] int_to_bcd(input int v, input int ndig);
    logic [31:0] r = '0;
    int x = v;
    for (int i = 0; i < ndig; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [55:0] exp_hex(input int v, input int ndig, input bit blank_lz);
    logic [55:0] r = '0;
    logic [6:0]  s;
    int pw = 1;
    for (int i = 0; i < ndig; i++) begin
      s = seg_pat((v / pw) % 10);
      if (blank_lz && i > 0 && v < pw) s = 7'h00;
      r[7*i +: 7] = ~s;
      pw = pw * 10;
    end
    return r;
  endfunction

  function automatic mstate_t next_state(input mstate_t s, input bit ld, input logic [31:0] lv,
                                         input int ndig, input bit req, input bit up,
                                         input bit wrap, input int top);
    mstate_t n;
    n    = s;
    n.tc = 1'b0;
    if (ld) begin
      if (nibbles_ok(lv, ndig) && bcd_to_int(lv, ndig) <= top) begin
        n.cnt = bcd_to_int(lv, ndig);
        n.ovf = 1'b0;
      end else begin
        n.err = 1'b1;
      end
    end else if (req) begin
      if (up) begin
        if (s.cnt == top) begin
          if (wrap) begin n.cnt = 0; n.tc = 1'b1; end
          else n.ovf = 1'b1;
        end else n.cnt = s.cnt + 1;
      end else begin
        if (s.cnt == 0) begin
          if (wrap) begin n.cnt = top; n.tc = 1'b1; end
          else n.ovf = 1'b1;
        end else n.cnt = s.cnt - 1;
      end
    end
    return n;
  endfunction

  task automatic compare(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    assert (got === want)
    else begin
      errors++;
      $error("[TB] FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic checkOutput(input string tag);
    logic [31:0] cb;
    logic [55:0] hx;
    cb = int_to_bcd(ma.cnt, 2);
    hx = exp_hex(ma.cnt, 2, 1'b0);
    compare({tag, ".a.count"}, 64'(count_a), 64'(cb[7:0]));
    compare({tag, ".a.hex"},   64'(hex_a),   64'(hx[13:0]));
    compare({tag, ".a.tc"},    64'(tc_a),    64'(ma.tc));
    compare({tag, ".a.ovf"},   64'(ovf_a),   64'(ma.ovf));
    compare({tag, ".a.err"},   64'(err_a),   64'(ma.err));
    cb = int_to_bcd(mb.cnt, 3);
    hx = exp_hex(mb.cnt, 3, 1'b1);
    compare({tag, ".b.count"}, 64'(count_b), 64'(cb[11:0]));
    compare({tag, ".b.hex"},   64'(hex_b),   64'(hx[20:0]));
    compare({tag, ".b.tc"},    64'(tc_b),    64'(mb.tc));
    compare({tag, ".b.ovf"},   64'(ovf_b),   64'(mb.ovf));
    compare({tag, ".b.err"},   64'(err_b),   64'(mb.err));
  endtask

  // Model: a step sample that is high after a low sample yields one count two edges later.
  task automatic tick(input string tag);
    bit req_a;
    @(posedge clk);
    edge_n++;
    req_a = 1'b0;
    if (due_a.size() > 0 && due_a[0] == edge_n) begin
      void'(due_a.pop_front());
      req_a = en_a;
    end
    if (step_a && !last_a) due_a.push_back(edge_n + 2);
    last_a = step_a;
    ma = next_state(ma, load_a, {24'd0, lv_a}, 2, req_a, up_a, wrap_a, TOP_A);
    mb = next_state(mb, load_b, {20'd0, lv_b}, 3, en_b, up_b, wrap_b, TOP_B);
    @(negedge clk);
    checkOutput(tag);
  endtask

  task automatic applyStimulus(input bit en, input bit stp, input bit up, input bit wrap,
                               input bit ld, input logic [7:0] lv, input string tag);
    en_a   = en;
    step_a = stp;
    up_a   = up;
    wrap_a = wrap;
    load_a = ld;
    lv_a   = lv;
    tick(tag);
  endtask

  task automatic pulse(input bit up, input bit wrap, input int hi, input string tag);
    for (int i = 0; i < hi; i++) applyStimulus(1, 1, up, wrap, 0, 8'h00, tag);
    for (int i = 0; i < 3; i++)  applyStimulus(1, 0, up, wrap, 0, 8'h00, tag);
  endtask

  task automatic doReset(input string tag);
    rst = 1'b1;
    #1;
    ma = '{cnt: 0, tc: 1'b0, ovf: 1'b0, err: 1'b0};
    mb = '{cnt: 0, tc: 1'b0, ovf: 1'b0, err: 1'b0};
    due_a.delete();
    last_a = 1'b0;
    checkOutput(tag);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    edge_n = 0;
    rst    = 1'b0;
    en_a = 0; step_a = 0; up_a = 1; wrap_a = 1; load_a = 0; lv_a = '0;
    en_b = 0; step_b = 0; up_b = 1; wrap_b = 1; load_b = 0; lv_b = '0;
    #2;
    doReset("rst");
    compare("rst.hex0", 64'(hex_a[6:0]), 64'(7'b1000000));

    // Full up cycle through the terminal value and back to zero.
    for (int p = 0; p < 60; p++) pulse(1, 1, int'($urandom_range(1, 3)), "t1");
    compare("t1.wrap", 64'(count_a), 64'(8'h00));

    // Carry and borrow across digits.
    applyStimulus(1, 0, 1, 1, 1, 8'h09, "t2.load");
    pulse(1, 1, 1, "t2.up");
    compare("t2.carry", 64'(count_a), 64'(8'h10));
    pulse(0, 1, 2, "t2.dn");
    pulse(0, 1, 1, "t2.dn");
    compare("t2.borrow", 64'(count_a), 64'(8'h08));

    // Saturate at zero, then clear ovf by a valid load.
    applyStimulus(1, 0, 0, 0, 1, 8'h00, "t3.load");
    pulse(0, 0, 1, "t3.sat");
    compare("t3.ovf", 64'(ovf_a), 64'(1'b1));
    applyStimulus(1, 0, 0, 0, 1, 8'h30, "t3.reload");
    compare("t3.ovfclr", 64'(ovf_a), 64'(1'b0));

    // Invalid loads, one colliding with a count request.
    applyStimulus(1, 0, 1, 1, 1, 8'h6A, "t4.bad1");
    compare("t4.err", 64'(err_a), 64'(1'b1));
    applyStimulus(1, 1, 1, 1, 0, 8'h00, "t4.s0");
    applyStimulus(1, 1, 1, 1, 0, 8'h00, "t4.s1");
    applyStimulus(1, 1, 1, 1, 1, 8'h75, "t4.bad2");
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 1, 1, 0, 8'h00, "t4.idle");
    compare("t4.hold", 64'(count_a), 64'(8'h30));

    // Long step high, then reset while it stays high.
    for (int i = 0; i < 20; i++) applyStimulus(1, 1, 1, 1, 0, 8'h00, "t5.hold");
    compare("t5.once", 64'(count_a), 64'(8'h31));
    doReset("t5.rst");
    for (int i = 0; i < 12; i++) applyStimulus(1, 1, 1, 1, 0, 8'h00, "t5.rehold");
    applyStimulus(1, 0, 1, 1, 0, 8'h00, "t5.rel");
    compare("t5.after", 64'(count_a), 64'(8'h01));

    // Leading-zero blanking and free-running count on the 3-digit counter.
    load_b = 1; lv_b = 12'h007;
    applyStimulus(0, 0, 1, 1, 0, 8'h00, "t6.load");
    load_b = 0;
    compare("t6.blank", 64'(hex_b), 64'({7'h7F, 7'h7F, 7'b1111000}));
    en_b = 1;
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 1, 1, 0, 8'h00, "t6.run");
    en_b = 0;
    compare("t6.count", 64'(count_b), 64'(12'h012));

    // Randomised traffic on both counters.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) doReset("rnd.rst");
      en_b   = ($urandom % 4) != 0;
      up_b   = $urandom % 2;
      wrap_b = $urandom % 2;
      load_b = ($urandom % 12) == 0;
      lv_b   = ($urandom % 2) ? int_to_bcd(int'($urandom_range(0, 999)), 3) : 12'($urandom);
      applyStimulus(($urandom % 4) != 0, $urandom % 2, $urandom % 2, $urandom % 2,
                    ($urandom % 10) == 0,
                    ($urandom % 2) ? int_to_bcd(int'($urandom_range(0, 59)), 2) : 8'($urandom),
                    "rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
